// File: rtl/rv32i_pkg.sv
// Shared definitions for the base register file arbiter: debug FSM state
// encoding, register index width, data width and a small x0 helper.
package rv32i_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  typedef enum logic [2:0] {
    DBG_IDLE    = 3'd0,
    DBG_DRAIN   = 3'd1,
    DBG_ACCESS  = 3'd2,
    DBG_CAPTURE = 3'd3,
    DBG_DONE    = 3'd4
  } dbg_state_e;

  // x0 is hardwired to zero; reads of it must never return stale data.
  function automatic logic is_x0(input logic [REG_IDX_W-1:0] idx);
    return (idx == {REG_IDX_W{1'b0}});
  endfunction

endpackage

// File: rtl/rv32i_basereg_arbiter_if.sv
// Debug access port bundle: a held request with opcode/address/data and a
// one-cycle acknowledge carrying error status and read data.
interface rv32i_basereg_arbiter_if;
  import rv32i_pkg::*;

  logic                 req;
  logic                 we;
  logic [REG_IDX_W-1:0] addr;
  logic [XLEN-1:0]      wdata;
  logic                 ack;
  logic                 err;
  logic [XLEN-1:0]      rdata;

  // Debug module side.
  modport master (
    output req, we, addr, wdata,
    input  ack, err, rdata
  );

  // Arbiter side.
  modport slave (
    input  req, we, addr, wdata,
    output ack, err, rdata
  );

endinterface

// File: rtl/rv32i_dbg_timeout.sv
// Loadable saturating cycle counter used to bound the pipeline drain wait.
// o_expired flags the cycle that completes LIMIT enabled cycles.
module rv32i_dbg_timeout #(
  parameter int LIMIT = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count_r;

  // Clear on load, otherwise count enabled cycles up to LIMIT and hold.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (i_load) begin
      count_r <= {CNT_W{1'b0}};
    end else if (i_en && (count_r != CNT_MAX)) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  // Expiry counts the current enabled cycle, so LIMIT cycles of waiting end it.
  assign o_expired = i_en && (count_r >= CNT_LAST);

endmodule

// File: rtl/rv32i_basereg_arbiter.sv
// Arbitrates the 32-entry base register file between the pipeline
// (decode reads, writeback writes) and a debug access port. A debug request
// stalls the pipeline, waits for it to drain, performs one access through
// the normal regfile ports and acknowledges.
module rv32i_basereg_arbiter
  import rv32i_pkg::*;
#(
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_dec_ce_read,
  input  logic [REG_IDX_W-1:0] i_dec_rs1_addr,
  input  logic [REG_IDX_W-1:0] i_dec_rs2_addr,
  input  logic                 i_wb_wr,
  input  logic [REG_IDX_W-1:0] i_wb_rd_addr,
  input  logic [XLEN-1:0]      i_wb_rd,
  input  logic                 i_pipe_idle,
  output logic                 o_stall_pipe,
  output logic                 o_ce_read,
  output logic [REG_IDX_W-1:0] o_rs1_addr,
  output logic [REG_IDX_W-1:0] o_rs2_addr,
  output logic                 o_wr,
  output logic [REG_IDX_W-1:0] o_rd_addr,
  output logic [XLEN-1:0]      o_rd,
  input  logic [XLEN-1:0]      i_rs1,
  rv32i_basereg_arbiter_if.slave dbg
);

  dbg_state_e           state_r;
  dbg_state_e           state_nx;
  logic                 we_r;
  logic [REG_IDX_W-1:0] addr_r;
  logic [XLEN-1:0]      wdata_r;
  logic [XLEN-1:0]      rdata_r;
  logic                 ack_r;
  logic                 err_r;

  logic                 latch_req;
  logic                 cnt_load;
  logic                 cnt_en;
  logic                 capture;
  logic                 err_nx;
  logic                 expired;

  rv32i_dbg_timeout #(
    .LIMIT(DRAIN_TIMEOUT)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_load   (cnt_load),
    .i_en     (cnt_en),
    .o_expired(expired)
  );

  // Next-state logic and regfile port muxing; writeback owns the write port
  // unless a debug write is actually being issued.
  always_comb begin
    state_nx     = state_r;
    latch_req    = 1'b0;
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;
    capture      = 1'b0;
    err_nx       = 1'b0;
    o_stall_pipe = 1'b1;
    o_ce_read    = 1'b0;
    o_rs1_addr   = addr_r;
    o_rs2_addr   = addr_r;
    o_wr         = i_wb_wr;
    o_rd_addr    = i_wb_rd_addr;
    o_rd         = i_wb_rd;

    case (state_r)
      DBG_IDLE: begin
        o_stall_pipe = 1'b0;
        o_ce_read    = i_dec_ce_read;
        o_rs1_addr   = i_dec_rs1_addr;
        o_rs2_addr   = i_dec_rs2_addr;
        if (dbg.req) begin
          state_nx  = DBG_DRAIN;
          latch_req = 1'b1;
          cnt_load  = 1'b1;
        end else begin
          state_nx  = DBG_IDLE;
        end
      end
      DBG_DRAIN: begin
        cnt_en = 1'b1;
        // A drained pipeline wins over a timeout in the same cycle.
        if (i_pipe_idle) begin
          state_nx = DBG_ACCESS;
        end else if (expired) begin
          state_nx = DBG_DONE;
          err_nx   = 1'b1;
        end else begin
          state_nx = DBG_DRAIN;
        end
      end
      DBG_ACCESS: begin
        if (we_r) begin
          // A late writeback keeps the write port; retry next cycle.
          if (!i_wb_wr) begin
            o_wr      = 1'b1;
            o_rd_addr = addr_r;
            o_rd      = wdata_r;
            state_nx  = DBG_DONE;
          end else begin
            state_nx  = DBG_ACCESS;
          end
        end else begin
          o_ce_read = 1'b1;
          state_nx  = DBG_CAPTURE;
        end
      end
      DBG_CAPTURE: begin
        capture  = 1'b1;
        state_nx = DBG_DONE;
      end
      DBG_DONE: begin
        state_nx = DBG_IDLE;
      end
      default: begin
        o_stall_pipe = 1'b0;
        state_nx     = DBG_IDLE;
      end
    endcase
  end

  // State register, request latches and registered debug responses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= DBG_IDLE;
      we_r    <= 1'b0;
      addr_r  <= {REG_IDX_W{1'b0}};
      wdata_r <= {XLEN{1'b0}};
      rdata_r <= {XLEN{1'b0}};
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nx;
      if (latch_req) begin
        we_r    <= dbg.we;
        addr_r  <= dbg.addr;
        wdata_r <= dbg.wdata;
      end
      if (capture) begin
        rdata_r <= is_x0(addr_r) ? {XLEN{1'b0}} : i_rs1;
      end
      ack_r <= (state_nx == DBG_DONE);
      err_r <= err_nx;
    end
  end

  assign dbg.ack   = ack_r;
  assign dbg.err   = err_r;
  assign dbg.rdata = rdata_r;

endmodule

// File: tb/tb_rv32i_basereg_arbiter.sv
// Self-checking bench for rv32i_basereg_arbiter. A behavioural regfile sits
// on the regfile ports; a separate reference copy tracks what the bench
// intended to write, so debug reads are checked against intent.
module tb_rv32i_basereg_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_ce;
  logic [4:0]  dec_rs1, dec_rs2;
  logic        wb_wr;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        pipe_idle;
  logic        stall, ce_read, wr;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] rd_data;
  logic [31:0] rs1_q;

  logic [31:0] rf     [32];
  logic [31:0] ref_rf [32];

  int errors = 0;
  int checks = 0;

  // Observations from the last debug transaction.
  int          obs_ack_cyc, obs_wr_cyc, obs_wr_cnt, obs_rd_cyc, obs_rd_cnt, obs_stall_bad;
  logic        obs_err, obs_post_stall, obs_post_ack;
  logic [4:0]  obs_wr_addr, obs_rd_addr;
  logic [31:0] obs_wr_data;

  rv32i_basereg_arbiter_if dbg_bus();

  rv32i_basereg_arbiter #(.DRAIN_TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_dec_ce_read(dec_ce), .i_dec_rs1_addr(dec_rs1), .i_dec_rs2_addr(dec_rs2),
    .i_wb_wr(wb_wr), .i_wb_rd_addr(wb_addr), .i_wb_rd(wb_data),
    .i_pipe_idle(pipe_idle), .o_stall_pipe(stall),
    .o_ce_read(ce_read), .o_rs1_addr(rs1_addr), .o_rs2_addr(rs2_addr),
    .o_wr(wr), .o_rd_addr(rd_addr), .o_rd(rd_data),
    .i_rs1(rs1_q), .dbg(dbg_bus)
  );

  always #5 clk = ~clk;

  // Behavioural register file: x0 discards writes, reads registered.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else begin
      if (wr && (rd_addr != 5'd0)) rf[rd_addr] <= rd_data;
      if (ce_read) rs1_q <= (rs1_addr == 5'd0) ? 32'd0 : rf[rs1_addr];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ref();
    for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
  endtask

  // One debug transaction; collision writebacks hit the first ACCESS cycles.
  task automatic dbg_txn(input logic we, input logic [4:0] addr, input logic [31:0] wd,
                         input int drain, input int collide,
                         input logic [4:0] cwb_addr, input logic [31:0] cwb_base);
    obs_ack_cyc = -1; obs_wr_cyc = -1; obs_wr_cnt = 0; obs_rd_cyc = -1; obs_rd_cnt = 0;
    obs_stall_bad = 0; obs_err = 1'b0; obs_wr_addr = 5'd0; obs_wr_data = 32'd0; obs_rd_addr = 5'd0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      step();
      if (cyc == 0) begin
        dbg_bus.req = 1'b1; dbg_bus.we = we; dbg_bus.addr = addr; dbg_bus.wdata = wd;
        dec_ce = 1'b0;
      end
      pipe_idle = (cyc >= 1 + drain);
      wb_wr     = (cyc >= 2 + drain) && (cyc < 2 + drain + collide);
      wb_addr   = cwb_addr;
      wb_data   = cwb_base + 32'(cyc);
      if (wb_wr && (cwb_addr != 5'd0)) ref_rf[cwb_addr] = wb_data;
      @(negedge clk);
      if ((cyc == 0) ? stall : !stall) obs_stall_bad++;
      if (wr && !wb_wr) begin
        obs_wr_cnt++; obs_wr_cyc = cyc; obs_wr_addr = rd_addr; obs_wr_data = rd_data;
      end
      if (ce_read && stall) begin
        obs_rd_cnt++; obs_rd_cyc = cyc; obs_rd_addr = rs1_addr;
      end
      if (dbg_bus.ack) begin
        obs_ack_cyc = cyc; obs_err = dbg_bus.err;
        dbg_bus.req = 1'b0;
        break;
      end
    end
    step();
    dbg_bus.req = 1'b0; wb_wr = 1'b0; pipe_idle = 1'b1;
    @(negedge clk);
    obs_post_stall = stall; obs_post_ack = dbg_bus.ack;
  endtask

  task automatic test_reset();
    rst = 1'b1; dbg_bus.req = 1'b0; dbg_bus.we = 1'b0; dbg_bus.addr = 5'd0; dbg_bus.wdata = 32'd0;
    dec_ce = 1'b0; dec_rs1 = 5'd0; dec_rs2 = 5'd0; wb_wr = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    pipe_idle = 1'b1;
    clear_ref();
    step(); step();
    rst = 1'b0; wb_wr = 1'b1; wb_addr = 5'd0; wb_data = 32'h0BAD_F00D;
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (dbg_bus.ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", dbg_bus.ack); end
    checks++; if (dbg_bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", dbg_bus.err); end
    checks++; if (dbg_bus.rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", dbg_bus.rdata); end
    checks++; if ((wr !== 1'b1) || (rd_data !== 32'h0BAD_F00D)) begin
      errors++; $display("FAIL reset_passthru got wr=%b d=%h exp wr=1 d=0badf00d", wr, rd_data);
    end
    step(); wb_wr = 1'b0;
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 16; i++) begin
      step();
      if (i == 0) begin
        wb_wr = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF; dec_ce = 1'b1; dec_rs1 = 5'd7; dec_rs2 = 5'd3;
      end else begin
        wb_wr = 1'($urandom); wb_addr = 5'($urandom); wb_data = $urandom;
        dec_ce = 1'($urandom); dec_rs1 = 5'($urandom); dec_rs2 = 5'($urandom);
      end
      if (wb_wr && (wb_addr != 5'd0)) ref_rf[wb_addr] = wb_data;
      @(negedge clk);
      checks++; if ((ce_read !== dec_ce) || (rs1_addr !== dec_rs1) || (rs2_addr !== dec_rs2)) begin
        errors++; $display("FAIL pass_read got ce=%b a1=%0d a2=%0d exp ce=%b a1=%0d a2=%0d",
                           ce_read, rs1_addr, rs2_addr, dec_ce, dec_rs1, dec_rs2);
      end
      checks++; if ((wr !== wb_wr) || (rd_addr !== wb_addr) || (rd_data !== wb_data)) begin
        errors++; $display("FAIL pass_write got wr=%b a=%0d d=%h exp wr=%b a=%0d d=%h",
                           wr, rd_addr, rd_data, wb_wr, wb_addr, wb_data);
      end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL pass_stall got=%b exp=0", stall); end
    end
    step(); wb_wr = 1'b0; dec_ce = 1'b0;
  endtask

  task automatic test_dbg_write();
    dbg_txn(1'b1, 5'd10, 32'h12345678, 0, 0, 5'd0, 32'd0);
    ref_rf[10] = 32'h12345678;
    checks++; if ((obs_wr_cnt !== 1) || (obs_wr_cyc !== 2)) begin
      errors++; $display("FAIL dwr_issue got cnt=%0d cyc=%0d exp cnt=1 cyc=2", obs_wr_cnt, obs_wr_cyc);
    end
    checks++; if ((obs_wr_addr !== 5'd10) || (obs_wr_data !== 32'h12345678)) begin
      errors++; $display("FAIL dwr_port got a=%0d d=%h exp a=10 d=12345678", obs_wr_addr, obs_wr_data);
    end
    checks++; if ((obs_ack_cyc !== 3) || (obs_err !== 1'b0)) begin
      errors++; $display("FAIL dwr_ack got cyc=%0d err=%b exp cyc=3 err=0", obs_ack_cyc, obs_err);
    end
    checks++; if ((obs_stall_bad !== 0) || (obs_post_stall !== 1'b0) || (obs_post_ack !== 1'b0)) begin
      errors++; $display("FAIL dwr_stall got bad=%0d post_stall=%b post_ack=%b exp 0/0/0",
                         obs_stall_bad, obs_post_stall, obs_post_ack);
    end
    dbg_txn(1'b0, 5'd10, 32'd0, 0, 0, 5'd0, 32'd0);
    checks++; if ((obs_rd_cnt !== 1) || (obs_rd_cyc !== 2) || (obs_rd_addr !== 5'd10)) begin
      errors++; $display("FAIL drd_issue got cnt=%0d cyc=%0d a=%0d exp cnt=1 cyc=2 a=10",
                         obs_rd_cnt, obs_rd_cyc, obs_rd_addr);
    end
    checks++; if ((obs_ack_cyc !== 4) || (obs_err !== 1'b0) || (obs_wr_cnt !== 0)) begin
      errors++; $display("FAIL drd_ack got cyc=%0d err=%b wr=%0d exp cyc=4 err=0 wr=0",
                         obs_ack_cyc, obs_err, obs_wr_cnt);
    end
    checks++; if (dbg_bus.rdata !== 32'h12345678) begin
      errors++; $display("FAIL drd_data got=%h exp=12345678", dbg_bus.rdata);
    end
  endtask

  task automatic test_reset_capture();
    step();
    dbg_bus.req = 1'b1; dbg_bus.we = 1'b0; dbg_bus.addr = 5'd10; pipe_idle = 1'b1;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0; dbg_bus.req = 1'b0;
    clear_ref();
    @(negedge clk);
    checks++; if ((stall !== 1'b0) || (dbg_bus.ack !== 1'b0) || (dbg_bus.rdata !== 32'd0)) begin
      errors++; $display("FAIL rst_capture got stall=%b ack=%b rdata=%h exp 0/0/0",
                         stall, dbg_bus.ack, dbg_bus.rdata);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      checks++; if ((dbg_bus.ack !== 1'b0) || (stall !== 1'b0)) begin
        errors++; $display("FAIL rst_no_ack got ack=%b stall=%b exp 0/0", dbg_bus.ack, stall);
      end
    end
  endtask

  task automatic test_collision();
    dbg_txn(1'b1, 5'd12, 32'hCAFE0012, 1, 2, 5'd12, 32'h5A5A0000);
    checks++; if ((obs_wr_cnt !== 1) || (obs_wr_cyc !== 5) || (obs_ack_cyc !== 6)) begin
      errors++; $display("FAIL collide_timing got cnt=%0d wr=%0d ack=%0d exp cnt=1 wr=5 ack=6",
                         obs_wr_cnt, obs_wr_cyc, obs_ack_cyc);
    end
    ref_rf[12] = 32'hCAFE0012;
    dbg_txn(1'b0, 5'd12, 32'd0, 0, 0, 5'd0, 32'd0);
    checks++; if (dbg_bus.rdata !== 32'hCAFE0012) begin
      errors++; $display("FAIL collide_order got=%h exp=cafe0012", dbg_bus.rdata);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] prev;
    ref_rf[9] = 32'h0000_9999;
    dbg_txn(1'b1, 5'd9, 32'h0000_9999, 0, 0, 5'd0, 32'd0);
    dbg_txn(1'b0, 5'd9, 32'd0, 0, 0, 5'd0, 32'd0);
    prev = dbg_bus.rdata;
    checks++; if (prev !== 32'h0000_9999) begin errors++; $display("FAIL tmo_setup got=%h exp=00009999", prev); end
    for (int k = 0; k < 2; k++) begin
      dbg_txn(1'(k == 0), 5'd3, 32'h7777_7777, 100, 0, 5'd0, 32'd0);
      checks++; if ((obs_ack_cyc !== 1 + TMO) || (obs_err !== 1'b1)) begin
        errors++; $display("FAIL tmo_ack got cyc=%0d err=%b exp cyc=%0d err=1", obs_ack_cyc, obs_err, 1 + TMO);
      end
      checks++; if ((obs_wr_cnt !== 0) || (obs_rd_cnt !== 0) || (dbg_bus.rdata !== prev)) begin
        errors++; $display("FAIL tmo_side got wr=%0d rd=%0d rdata=%h exp 0/0/%h",
                           obs_wr_cnt, obs_rd_cnt, dbg_bus.rdata, prev);
      end
    end
  endtask

  task automatic test_x0();
    dbg_txn(1'b1, 5'd0, 32'hFFFFFFFF, 0, 0, 5'd0, 32'd0);
    checks++; if ((obs_ack_cyc !== 3) || (obs_err !== 1'b0) || (obs_wr_cnt !== 1)) begin
      errors++; $display("FAIL x0_write got ack=%0d err=%b wr=%0d exp 3/0/1", obs_ack_cyc, obs_err, obs_wr_cnt);
    end
    dbg_txn(1'b0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0);
    checks++; if ((obs_ack_cyc !== 4) || (dbg_bus.rdata !== 32'd0)) begin
      errors++; $display("FAIL x0_read got ack=%0d rdata=%h exp 4/0", obs_ack_cyc, dbg_bus.rdata);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 30; n++) begin
      logic        we;
      logic [4:0]  addr, cwa;
      logic [31:0] wd, cwb;
      int          drain, collide, exp_ack;
      we = 1'($urandom); addr = 5'($urandom); wd = $urandom;
      drain = $urandom_range(0, 2); collide = we ? $urandom_range(0, 2) : 0;
      cwa = 5'($urandom); cwb = $urandom;
      dbg_txn(we, addr, wd, drain, collide, cwa, cwb);
      exp_ack = we ? (3 + drain + collide) : (4 + drain);
      checks++; if ((obs_ack_cyc !== exp_ack) || (obs_err !== 1'b0)) begin
        errors++; $display("FAIL rnd_ack n=%0d got cyc=%0d err=%b exp cyc=%0d err=0", n, obs_ack_cyc, obs_err, exp_ack);
      end
      checks++; if ((obs_stall_bad !== 0) || (obs_post_stall !== 1'b0) || (obs_post_ack !== 1'b0)) begin
        errors++; $display("FAIL rnd_stall n=%0d got bad=%0d post=%b/%b exp 0/0/0", n, obs_stall_bad, obs_post_stall, obs_post_ack);
      end
      if (we) begin
        checks++; if ((obs_wr_cnt !== 1) || (obs_wr_cyc !== 2 + drain + collide) ||
                      (obs_wr_addr !== addr) || (obs_wr_data !== wd) || (obs_rd_cnt !== 0)) begin
          errors++; $display("FAIL rnd_write n=%0d got cnt=%0d cyc=%0d a=%0d d=%h exp cnt=1 cyc=%0d a=%0d d=%h",
                             n, obs_wr_cnt, obs_wr_cyc, obs_wr_addr, obs_wr_data, 2 + drain + collide, addr, wd);
        end
        if (addr != 5'd0) ref_rf[addr] = wd;
      end else begin
        checks++; if ((obs_rd_cnt !== 1) || (obs_rd_cyc !== 2 + drain) || (obs_rd_addr !== addr) || (obs_wr_cnt !== 0)) begin
          errors++; $display("FAIL rnd_readport n=%0d got cnt=%0d cyc=%0d a=%0d exp cnt=1 cyc=%0d a=%0d",
                             n, obs_rd_cnt, obs_rd_cyc, obs_rd_addr, 2 + drain, addr);
        end
        checks++; if (dbg_bus.rdata !== ((addr == 5'd0) ? 32'd0 : ref_rf[addr])) begin
          errors++; $display("FAIL rnd_rdata n=%0d x%0d got=%h exp=%h", n, addr, dbg_bus.rdata,
                             (addr == 5'd0) ? 32'd0 : ref_rf[addr]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_dbg_write();
    test_reset_capture();
    test_collision();
    test_timeout();
    test_x0();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
